// File: rtl/blob_tracker.sv
// Per-frame colour-blob tracker: counts target pixels in equal-width column zones,
// then reports the busiest zone, the frame total and a persistence-filtered detect flag.
module blob_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int N_ZONES    = 4,
    parameter int COUNT_W    = 19,
    parameter int MIN_PIXELS = 100,
    parameter int PERSIST    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pixel_valid,
    input  logic                       vsync,
    input  logic                       is_orange,
    output logic [$clog2(N_ZONES)-1:0] zone_idx,
    output logic [COUNT_W-1:0]         total_count,
    output logic                       detected,
    output logic                       result_valid,
    output logic                       overrun
);

    localparam int ZONE_W = H_ACTIVE / N_ZONES;
    localparam int ZI_W   = $clog2(N_ZONES);
    localparam int X_W    = $clog2(H_ACTIVE + 1);
    localparam int P_W    = $clog2(PERSIST + 1);
    localparam int CMP_W  = (COUNT_W > 32) ? COUNT_W : 32;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

    state_t               r_state, w_nextState;
    logic                 r_vsync, r_armed, r_frameEnd;
    logic [X_W-1:0]       r_x, r_boundary;
    logic [ZI_W-1:0]      r_z;
    logic [COUNT_W-1:0]   r_acc    [N_ZONES];
    logic [COUNT_W-1:0]   r_shadow [N_ZONES];
    logic [COUNT_W-1:0]   w_accNext[N_ZONES];
    logic [ZI_W-1:0]      r_scanIdx, r_maxIdx, w_maxIdxNext;
    logic [COUNT_W-1:0]   r_maxVal, r_sum, w_val, w_sumNext, w_maxValNext;
    logic [COUNT_W:0]     w_sumWide;
    logic [P_W-1:0]       r_persist, w_persistNext;
    logic                 w_snap, w_lastZone, w_hit;
    logic [ZI_W-1:0]      r_zoneIdx;
    logic [COUNT_W-1:0]   r_totalCount;
    logic                 r_detected, r_resultValid, r_overrun;

    assign zone_idx     = r_zoneIdx;
    assign total_count  = r_totalCount;
    assign detected     = r_detected;
    assign result_valid = r_resultValid;
    assign overrun      = r_overrun;

    // Frame end needs vsync to have been seen high since reset, so a vsync held low
    // across reset release cannot fake a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync    <= 1'b1;
            r_armed    <= 1'b0;
            r_frameEnd <= 1'b0;
        end else begin
            r_vsync    <= vsync;
            r_armed    <= r_armed | vsync;
            r_frameEnd <= r_armed & r_vsync & ~vsync;
        end
    end

    // Zone boundaries are tracked with a running compare value instead of a divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_z        <= '0;
            r_boundary <= X_W'(ZONE_W - 1);
        end else if (pixel_valid) begin
            if (r_x != '1)
                r_x <= r_x + 1'b1;
            if (r_x == r_boundary && r_z != ZI_W'(N_ZONES - 1)) begin
                r_z        <= r_z + 1'b1;
                r_boundary <= r_boundary + X_W'(ZONE_W);
            end
        end else begin
            r_x        <= '0;
            r_z        <= '0;
            r_boundary <= X_W'(ZONE_W - 1);
        end
    end

    always_comb begin
        for (int i = 0; i < N_ZONES; i++) begin
            w_accNext[i] = w_snap ? '0 : r_acc[i];
            if (pixel_valid && is_orange && r_z == ZI_W'(i) && w_accNext[i] != CNT_MAX)
                w_accNext[i] = w_accNext[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ZONES; i++) begin
                r_acc[i]    <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_acc <= w_accNext;
            if (w_snap)
                r_shadow <= r_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_snap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_frameEnd) begin
                    w_snap      = 1'b1;
                    w_nextState = SCAN;
                end
            end
            SCAN:    if (w_lastZone) w_nextState = UPDATE;
            UPDATE:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Strict greater-than keeps the lower zone on ties and zone 0 on an empty frame.
    always_comb begin
        w_lastZone   = (r_scanIdx == ZI_W'(N_ZONES - 1));
        w_val        = r_shadow[r_scanIdx];
        w_sumWide    = {1'b0, r_sum} + {1'b0, w_val};
        w_sumNext    = w_sumWide[COUNT_W] ? CNT_MAX : w_sumWide[COUNT_W-1:0];
        w_maxValNext = r_maxVal;
        w_maxIdxNext = r_maxIdx;
        if (w_val > r_maxVal) begin
            w_maxValNext = w_val;
            w_maxIdxNext = r_scanIdx;
        end
        w_hit = (CMP_W'(w_sumNext) >= CMP_W'(MIN_PIXELS));
        if (!w_hit)
            w_persistNext = '0;
        else if (r_persist == P_W'(PERSIST))
            w_persistNext = r_persist;
        else
            w_persistNext = r_persist + 1'b1;
    end

    // Results are registered on the last scan step so they are visible during UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scanIdx     <= '0;
            r_sum         <= '0;
            r_maxVal      <= '0;
            r_maxIdx      <= '0;
            r_persist     <= '0;
            r_zoneIdx     <= '0;
            r_totalCount  <= '0;
            r_detected    <= 1'b0;
            r_resultValid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_resultValid <= 1'b0;
            if (r_frameEnd && r_state != IDLE)
                r_overrun <= 1'b1;
            if (w_snap) begin
                r_scanIdx <= '0;
                r_sum     <= '0;
                r_maxVal  <= '0;
                r_maxIdx  <= '0;
            end else if (r_state == SCAN) begin
                r_scanIdx <= r_scanIdx + 1'b1;
                r_sum     <= w_sumNext;
                r_maxVal  <= w_maxValNext;
                r_maxIdx  <= w_maxIdxNext;
                if (w_lastZone) begin
                    r_zoneIdx     <= w_maxIdxNext;
                    r_totalCount  <= w_sumNext;
                    r_resultValid <= 1'b1;
                    r_persist     <= w_persistNext;
                    r_detected    <= (w_persistNext == P_W'(PERSIST));
                end
            end
        end
    end

endmodule

// File: tb/tb_blob_tracker.sv
// Randomised/directed bench for blob_tracker: a frame-level counting model predicts
// each result; a second instance with COUNT_W=4 exercises saturation.
module tb_blob_tracker;

    localparam int H     = 640;
    localparam int NZ    = 4;
    localparam int ZW    = H / NZ;
    localparam int MINP  = 100;
    localparam int PERS  = 3;
    localparam int MAX_A = (1 << 19) - 1;
    localparam int MAX_B = 15;

    logic        clk, rst_n, pixel_valid, vsync, is_orange;
    logic [1:0]  zoneIdxA, zoneIdxB;
    logic [18:0] totalA;
    logic [3:0]  totalB;
    logic        detA, rvA, ovA, detB, rvB, ovB;

    int nChecks = 0;
    int nPass   = 0;
    int rvCount = 0;
    int mCnt[NZ];
    int mPers   = 0;
    bit mOverrun = 0;

    blob_tracker dutA (
        .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .vsync(vsync),
        .is_orange(is_orange), .zone_idx(zoneIdxA), .total_count(totalA),
        .detected(detA), .result_valid(rvA), .overrun(ovA)
    );

    blob_tracker #(.COUNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .vsync(vsync),
        .is_orange(is_orange), .zone_idx(zoneIdxB), .total_count(totalB),
        .detected(detB), .result_valid(rvB), .overrun(ovB)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) if (rvA === 1'b1) rvCount <= rvCount + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Frame result from per-zone counts: clip each zone, sum with clipping, first maximum wins.
    task automatic modelFrame(input int maxv, output int expIdx, output int expTotal);
        int best;
        best = -1;
        expIdx = 0;
        expTotal = 0;
        for (int z = 0; z < NZ; z++) begin
            int c;
            c = (mCnt[z] > maxv) ? maxv : mCnt[z];
            expTotal += c;
            if (c > best) begin
                best = c;
                expIdx = z;
            end
        end
        if (expTotal > maxv) expTotal = maxv;
    endtask

    // One line of pixels: orange inside [lo1,hi1] or [lo2,hi2], or random density/1000 if dens>=0.
    task automatic applyStimulus(input int lo1, input int hi1, input int lo2, input int hi2, input int dens);
        for (int x = 0; x < H; x++) begin
            bit o;
            if (dens >= 0) o = ($urandom_range(0, 999) < dens);
            else o = (x >= lo1 && x <= hi1) || (x >= lo2 && x <= hi2);
            pixel_valid = 1'b1;
            is_orange = o;
            if (o) mCnt[x / ZW]++;
            tick();
        end
        pixel_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            is_orange = 1'($urandom_range(0, 1));
            tick();
        end
        is_orange = 1'b0;
    endtask

    task automatic frameEnd(input bit dbl);
        int n, eIdx, eTot, eIdxB, eTotB;
        modelFrame(MAX_A, eIdx, eTot);
        modelFrame(MAX_B, eIdxB, eTotB);
        mPers = (eTot >= MINP) ? ((mPers < PERS) ? mPers + 1 : PERS) : 0;
        for (int z = 0; z < NZ; z++) mCnt[z] = 0;
        if (dbl) mOverrun = 1'b1;
        vsync = 1'b0;
        tick();
        n = 0;
        if (dbl) begin
            vsync = 1'b1;
            tick();
            n++;
            vsync = 1'b0;
            tick();
            n++;
        end
        vsync = 1'b1;
        while (rvA !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("latency", n, NZ + 1);
        checkOutput("zone_idx", zoneIdxA, eIdx);
        checkOutput("total_count", totalA, eTot);
        checkOutput("detected", detA, (mPers == PERS));
        checkOutput("overrun", ovA, mOverrun);
        checkOutput("w4_result_valid", rvB, 1);
        checkOutput("w4_zone_idx", zoneIdxB, eIdxB);
        checkOutput("w4_total_count", totalB, eTotB);
        checkOutput("w4_detected", detB, 0);
        tick();
        checkOutput("rv_single_cycle", rvA, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_zone_idx"}, zoneIdxA, 0);
        checkOutput({tag, "_total"}, totalA, 0);
        checkOutput({tag, "_detected"}, detA, 0);
        checkOutput({tag, "_result_valid"}, rvA, 0);
        checkOutput({tag, "_overrun"}, ovA, 0);
        checkOutput({tag, "_w4_total"}, totalB, 0);
        checkOutput({tag, "_w4_overrun"}, ovB, 0);
    endtask

    initial begin
        int rvBefore;
        for (int z = 0; z < NZ; z++) mCnt[z] = 0;
        rst_n = 1'b0;
        vsync = 1'b0;
        pixel_valid = 1'b0;
        is_orange = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");

        // vsync held low across reset release must not start a frame
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("no_frame_at_release", rvCount, 0);
        vsync = 1'b1;
        repeat (3) tick();

        repeat (4) applyStimulus(0, 49, -1, -1, -1);
        frameEnd(0);

        frameEnd(0);
        repeat (3) begin
            applyStimulus(320, 439, -1, -1, -1);
            frameEnd(0);
        end
        frameEnd(0);

        applyStimulus(160, 189, 480, 509, -1);
        frameEnd(0);

        repeat (4) begin
            int dens;
            dens = $urandom_range(0, 200);
            repeat (2) applyStimulus(-1, -1, -1, -1, dens);
            frameEnd(0);
        end

        // orange flag with no valid strobe, then a second vsync fall during the scan
        pixel_valid = 1'b0;
        is_orange = 1'b1;
        repeat (700) tick();
        is_orange = 1'b0;
        rvBefore = rvCount;
        frameEnd(1);
        repeat (20) tick();
        checkOutput("single_result_on_overrun", rvCount - rvBefore, 1);

        applyStimulus(0, 19, -1, -1, -1);
        frameEnd(0);

        // reset asserted in the middle of a scan, with a couple of pixels already accumulated
        applyStimulus(0, 99, -1, -1, -1);
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        pixel_valid = 1'b1;
        is_orange = 1'b1;
        tick();
        tick();
        pixel_valid = 1'b0;
        is_orange = 1'b0;
        rvBefore = rvCount;
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        for (int z = 0; z < NZ; z++) mCnt[z] = 0;
        mPers = 0;
        mOverrun = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (15) tick();
        checkOutput("no_result_after_reset", rvCount - rvBefore, 0);
        applyStimulus(600, 609, -1, -1, -1);
        frameEnd(0);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
